// File: rtl/pdm_modulator.sv
// pdm_modulator: first-order sigma-delta modulator, 8-bit signed PCM in, 1-bit PDM out
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable_i           1 = modulate, 0 = idle (counters, accumulator cleared; FIFO kept)
//   sample_in_i        signed PCM sample, accepted when sample_valid_i && sample_ready_o
//   sample_valid_i     sample_in_i is valid
//   sample_ready_o     FIFO not full (registered occupancy)
//   pdm_out_o          PDM bitstream
//   bit_strobe_o       one-clk pulse when pdm_out_o takes a new bit
//   underrun_o         one-clk pulse with the strobe of a sample boundary that found the FIFO empty
module pdm_modulator #(
  parameter int DIV   = 100,
  parameter int OSR   = 16,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic [7:0] sample_in_i,
  input  logic       sample_valid_i,
  output logic       sample_ready_o,
  output logic       pdm_out_o,
  output logic       bit_strobe_o,
  output logic       underrun_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(OSR);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic ready_q;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0] acc_q, acc_d, cur_q, cur_d;
  logic pdm_q, pdm_d, stb_q, stb_d, und_q, und_d;
  logic push, pop, empty, compute, last;
  logic [8:0] sum;
  assign push = sample_valid_i && ready_q;
  assign empty = cnt_q == '0;
  assign compute = div_q == DW'(DIV - 1);
  assign last = bit_q == BW'(OSR - 1);
  // offset-binary view of the sample (MSB inverted = +128), carry out is the PDM bit
  assign sum = {1'b0, acc_q} + {1'b0, ~cur_q[7], cur_q[6:0]};
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    div_d = div_q;
    bit_d = bit_q;
    acc_d = acc_q;
    cur_d = cur_q;
    pdm_d = pdm_q;
    stb_d = 1'b0;
    und_d = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        acc_d = '0;
        pdm_d = 1'b0;
        state_d = enable_i ? PRIME : IDLE;
      end
      PRIME: begin
        pdm_d = 1'b0;
        if (!enable_i) state_d = IDLE;
        else if (!empty) begin
          pop = 1'b1;
          cur_d = mem_q[rd_q];
          div_d = '0;
          bit_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          div_d = '0;
          bit_d = '0;
          acc_d = '0;
          cur_d = '0;
          pdm_d = 1'b0;
        end else begin
          div_d = compute ? '0 : div_q + 1'b1;
          if (compute) begin
            acc_d = sum[7:0];
            pdm_d = sum[8];
            stb_d = 1'b1;
            bit_d = last ? '0 : bit_q + 1'b1;
            pop = last && !empty;
            und_d = last && empty;
            // an empty FIFO at the boundary falls back to mid-scale silence
            if (last) cur_d = empty ? 8'd0 : mem_q[rd_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= sample_in_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
      div_q <= '0;
      bit_q <= '0;
      acc_q <= '0;
      cur_q <= '0;
      pdm_q <= 1'b0;
      stb_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= push ? wr_q + 1'b1 : wr_q;
      rd_q <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_d;
      ready_q <= cnt_d != (AW+1)'(DEPTH);
      div_q <= div_d;
      bit_q <= bit_d;
      acc_q <= acc_d;
      cur_q <= cur_d;
      pdm_q <= pdm_d;
      stb_q <= stb_d;
      und_q <= und_d;
    end
  end
  assign sample_ready_o = ready_q;
  assign pdm_out_o = pdm_q;
  assign bit_strobe_o = stb_q;
  assign underrun_o = und_q;
endmodule

// File: tb/tb_pdm_modulator.sv
// tb_pdm_modulator: self-checking bench for pdm_modulator (DIV=4, OSR=16, DEPTH=4)
module tb_pdm_modulator;
  localparam int DIV = 4, OSR = 16, DEPTH = 4, LIM = 4000;
  logic clk = 0, rst_n = 0, enable_i = 0, sample_valid_i = 0;
  logic [7:0] sample_in_i = '0;
  logic sample_ready_o, pdm_out_o, bit_strobe_o, underrun_o;
  int total = 0, bad = 0, m_acc = 0;
  int strb_cnt = 0, ones_cnt = 0, und_cnt = 0;
  typedef struct {logic pdm; logic und;} exp_t;
  typedef struct {logic [7:0] s; int ones;} vec_t;
  exp_t sbq[$];
  vec_t tbl[8];
  pdm_modulator #(.DIV(DIV), .OSR(OSR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .sample_in_i(sample_in_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .pdm_out_o(pdm_out_o), .bit_strobe_o(bit_strobe_o), .underrun_o(underrun_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask
  function automatic void add_sample(input logic [7:0] s, input logic und_last);
    int u = $signed(s) + 128;
    exp_t e;
    for (int i = 0; i < OSR; i++) begin
      m_acc = m_acc + u;
      e.pdm = m_acc > 255;
      e.und = und_last && (i == OSR - 1);
      m_acc = m_acc % 256;
      sbq.push_back(e);
    end
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (bit_strobe_o) begin
      strb_cnt++;
      if (pdm_out_o) ones_cnt++;
      if (underrun_o) und_cnt++;
      check("sb_expect_avail", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb_pdm", pdm_out_o, e.pdm);
        check("sb_underrun", underrun_o, e.und);
      end
    end else check("underrun_aligned", underrun_o, 0);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic half();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] s);
    int n = 0;
    sample_in_i = s;
    sample_valid_i = 1;
    while (!sample_ready_o && n < LIM) begin
      tick();
      n++;
    end
    check("push_ready", sample_ready_o, 1);
    tick();
    sample_valid_i = 0;
  endtask
  task automatic wait_strobes(input int n, output int cyc);
    int seen = 0;
    cyc = 0;
    while (seen < n && cyc < LIM) begin
      tick();
      cyc++;
      if (bit_strobe_o) seen++;
    end
    check("strobe_wait", seen, n);
  endtask
  task automatic stop(input logic flush);
    enable_i = 0;
    repeat (3) tick();
    if (flush) sbq.delete();
    check("sb_drained", sbq.size(), 0);
    m_acc = 0;
  endtask
  initial begin
    int c, o0, u0, s0, n;
    tbl[0] = '{8'h00, 128};
    tbl[1] = '{8'h7F, 255};
    tbl[2] = '{8'h80, 0};
    tbl[3] = '{8'hFF, 127};
    tbl[4] = '{8'h01, 129};
    tbl[5] = '{8'h40, 192};
    tbl[6] = '{8'hC0, 64};
    tbl[7] = '{8'h64, 228};
    #2;
    check("rst_pdm", pdm_out_o, 0);
    check("rst_strobe", bit_strobe_o, 0);
    check("rst_underrun", underrun_o, 0);
    repeat (3) tick();
    rst_n = 1;
    tick();
    check("rst_ready", sample_ready_o, 1);
    s0 = strb_cnt;
    repeat (20) tick();
    check("idle_no_strobe", strb_cnt - s0, 0);
    check("idle_pdm", pdm_out_o, 0);
    // mid-scale: alternating bits, first strobe DIV cycles after RUN entry
    push(8'h00);
    add_sample(8'h00, 1);
    o0 = ones_cnt;
    u0 = und_cnt;
    enable_i = 1;
    wait_strobes(1, c);
    check("first_strobe_lat", c, 2 + DIV);
    wait_strobes(1, c);
    check("strobe_period", c, DIV);
    wait_strobes(14, c);
    half();
    check("mid_ones", ones_cnt - o0, 8);
    check("mid_underrun", und_cnt - u0, 1);
    stop(0);
    // full scale then minimum scale, accumulator carried across the boundary
    push(8'h7F);
    add_sample(8'h7F, 0);
    push(8'h80);
    add_sample(8'h80, 0);
    push(8'h80);
    add_sample(8'h80, 0);
    o0 = ones_cnt;
    u0 = und_cnt;
    enable_i = 1;
    wait_strobes(16, c);
    check("acc_boundary1", dut.acc_q, 240);
    half();
    check("max_ones", ones_cnt - o0, 15);
    o0 = ones_cnt;
    wait_strobes(16, c);
    check("acc_boundary2", dut.acc_q, 240);
    half();
    check("min_ones", ones_cnt - o0, 0);
    check("extreme_underrun", und_cnt - u0, 0);
    stop(1);
    // FIFO fills with enable low, fifth sample held until PRIME frees a slot
    for (int i = 0; i < 4; i++) begin
      push(8'(10 * (i + 1)));
      add_sample(8'(10 * (i + 1)), 0);
    end
    check("full_ready", sample_ready_o, 0);
    sample_in_i = 8'd50;
    sample_valid_i = 1;
    repeat (5) begin
      tick();
      check("full_hold_ready", sample_ready_o, 0);
    end
    u0 = und_cnt;
    enable_i = 1;
    tick();
    check("prime_ready", sample_ready_o, 0);
    tick();
    check("pop_ready", sample_ready_o, 1);
    tick();
    check("refill_ready", sample_ready_o, 0);
    sample_valid_i = 0;
    add_sample(8'd50, 1);
    wait_strobes(80, c);
    half();
    check("fifo_order_underrun", und_cnt - u0, 1);
    stop(0);
    // single sample then starvation: underrun repeats every OSR bits at silence
    push(8'h7F);
    add_sample(8'h7F, 1);
    add_sample(8'h00, 1);
    u0 = und_cnt;
    enable_i = 1;
    wait_strobes(16, c);
    half();
    check("starve_underrun1", und_cnt - u0, 1);
    wait_strobes(16, c);
    half();
    check("starve_underrun2", und_cnt - u0, 2);
    stop(0);
    // enable drop in the middle of a sample, then restart from acc=0
    push(8'h00);
    add_sample(8'h00, 1);
    enable_i = 1;
    wait_strobes(8, c);
    check("pre_drop_pdm", pdm_out_o, 1);
    enable_i = 0;
    tick();
    check("drop_pdm", pdm_out_o, 0);
    s0 = strb_cnt;
    repeat (20) tick();
    check("drop_no_strobe", strb_cnt - s0, 0);
    sbq.delete();
    m_acc = 0;
    push(8'h00);
    add_sample(8'h00, 1);
    o0 = ones_cnt;
    enable_i = 1;
    wait_strobes(1, c);
    check("restart_lat", c, 2 + DIV);
    wait_strobes(15, c);
    half();
    check("restart_ones", ones_cnt - o0, 8);
    stop(0);
    // asynchronous reset in the middle of a sample also empties the FIFO
    push(8'h00);
    add_sample(8'h00, 0);
    push(8'h00);
    enable_i = 1;
    wait_strobes(8, c);
    check("pre_rst_pdm", pdm_out_o, 1);
    check("pre_rst_strobe", bit_strobe_o, 1);
    #1 rst_n = 0;
    #1;
    check("async_rst_pdm", pdm_out_o, 0);
    check("async_rst_strobe", bit_strobe_o, 0);
    repeat (2) tick();
    sbq.delete();
    m_acc = 0;
    rst_n = 1;
    tick();
    check("post_rst_ready", sample_ready_o, 1);
    o0 = ones_cnt;
    u0 = und_cnt;
    push(8'h00);
    add_sample(8'h00, 1);
    wait_strobes(16, c);
    half();
    check("post_rst_ones", ones_cnt - o0, 8);
    check("post_rst_underrun", und_cnt - u0, 1);
    stop(0);
    // density over 256 bits at constant input equals the offset-binary code
    foreach (tbl[k]) begin
      o0 = ones_cnt;
      u0 = und_cnt;
      s0 = strb_cnt;
      enable_i = 1;
      for (int i = 0; i < 16; i++) begin
        push(tbl[k].s);
        add_sample(tbl[k].s, i == 15);
      end
      n = 0;
      while (strb_cnt - s0 < 256 && n < LIM) begin
        half();
        n++;
      end
      check("density_strobes", strb_cnt - s0, 256);
      check("density_ones", ones_cnt - o0, tbl[k].ones);
      check("density_underrun", und_cnt - u0, 1);
      stop(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pdm_modulator.md
Name: pdm_modulator

Overview:
- First-order sigma-delta modulator. Turns 8-bit signed PCM samples into a 1-bit PDM stream.
- Transmit-side counterpart of the PDM audio input path: it produces the one-pin stream the PDM-to-PCM sampler consumes.
- Used as an on-chip test-tone source and as a loopback driver for the spectrum analyzer chain.
- Samples enter through a valid/ready handshake into a small FIFO. Each sample is emitted as OSR PDM bits, one bit per bit strobe.

Parameters:
- DIV, 100, clk cycles per PDM bit (bit strobe period), ≥2
- OSR, 16, PDM bits emitted per PCM sample, ≥2
- DEPTH, 4, sample FIFO depth, power of 2, ≥2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = modulate; 0 = idle, counters and accumulator cleared
- sample_in  in  8  signed PCM sample
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  FIFO can accept a sample (= not full)
- pdm_out  out  1  PDM bitstream
- bit_strobe  out  1  one-clk pulse in the cycle pdm_out takes a new bit
- underrun  out  1  one-clk pulse: sample boundary reached with FIFO empty

Behaviour:
- Reset (async): state=IDLE, FIFO empty, acc=0, div_cnt=0, bit_cnt=0, cur=0. Outputs: pdm_out=0, bit_strobe=0, underrun=0. sample_ready=1 from the first clk after reset release.
- Push: sample_valid && sample_ready at a clk edge writes sample_in into the FIFO.
  - sample_ready = !full, derived from registered occupancy only.
  - A pop in the same cycle does not raise sample_ready in that cycle.
  - Pushes are accepted in every state.
- FSM IDLE:
  - pdm_out=0; acc, div_cnt and bit_cnt held at 0.
  - FIFO contents are retained.
  - enable=1 → PRIME.
- FSM PRIME:
  - No strobes; pdm_out=0.
  - If FIFO non-empty: pop into cur, div_cnt=0, bit_cnt=0, go to RUN.
  - enable=0 → IDLE, which takes priority.
- FSM RUN:
  - div_cnt increments each clk and wraps DIV-1→0. The compute cycle is div_cnt==DIV-1.
  - On a compute cycle, with u = cur + 128 as an unsigned 8-bit value (two's complement, MSB inverted):
    - {carry, acc_next} = acc + u, 9-bit sum.
    - acc <= acc_next; pdm_out <= carry; bit_strobe <= 1 for the next cycle only.
    - The new pdm_out and bit_strobe are visible together at the edge after the compute cycle.
  - On a compute cycle with bit_cnt==OSR-1 (last bit of the sample), bit_cnt wraps to 0 and:
    - FIFO non-empty: pop into cur.
    - FIFO empty: cur <= 0 (mid-scale silence) and underrun pulses for one clk, aligned with bit_strobe.
    - Otherwise bit_cnt increments.
  - acc is NOT cleared between samples; it carries across sample boundaries.
- First strobe after entering RUN: bit_strobe high on cycle DIV relative to the first RUN cycle (cycle 0).
- enable falling in RUN: next edge → IDLE. pdm_out=0, acc/div_cnt/bit_cnt cleared. The partially emitted sample in cur is discarded; FIFO is kept.
- A push and a pop in the same cycle leave occupancy unchanged. A full FIFO cannot be pushed because ready=0.
- Density: over 256 consecutive bits at constant cur, the count of ones equals u exactly.
- Async reset mid-RUN: every register returns to its reset value immediately, with no wait for a clock.

Test Plan:
1. Reset with DIV=4, OSR=16 → pdm_out=0, bit_strobe=0, underrun=0, sample_ready=1. No strobes while enable=0.
2. Push 0, enable=1 → bit_strobe every 4 clk. pdm_out bits 0,1,0,1,… giving exactly 8 ones in 16 bits. First strobe 4 clk after RUN entry.
3. Push +127 then -128, then keep supplying -128:
   - First 16 bits: 0 then fifteen 1s; acc=240 at the sample boundary.
   - Next 16 bits: all 0, with acc staying at 240.
   - No underrun pulses.
4. enable=0, push 5 consecutive samples → 4 accepted, sample_ready=0 on the 5th (held until accepted). After enable=1, PRIME pops the first sample and sample_ready returns to 1 the following clk.
5. Push a single +127 then nothing → underrun pulses once, coincident with the 16th bit_strobe. The following 16 bits are emitted at u=128 and underrun pulses again at their end.
6. Mid-sample enable drop at bit 7 → pdm_out=0 next clk and strobes stop. Re-enable with the FIFO holding 0 → sequence restarts from acc=0 as in scenario 2. Repeat using rst_n instead → identical restart, with the FIFO emptied.
